// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Streams words from a combinational
//               ROM into a small FIFO, stops after enqueuing a halt marker
//               (opcode 4'b1111), and supports redirects and restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [9:0]  rom_addr,
  input  logic [17:0] rom_data,
  input  logic        redirect,
  input  logic [9:0]  redirect_addr,
  output logic [17:0] instr,
  output logic [9:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [9:0]       pc_q;
  logic [17:0]      word_q [DEPTH];
  logic [9:0]       addr_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic not_empty;
  logic full;
  logic flush;
  logic pop;
  logic enq;
  logic is_halt;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // Redirect (any active state) or restart from HALT empties the buffer.
  assign flush     = (state_q != IDLE) && (redirect || ((state_q == HALT) && start));
  assign pop       = not_empty && instr_ready && !flush;
  // A full buffer can still accept a word when the head leaves this cycle.
  assign enq       = (state_q == FETCH) && !redirect && (!full || pop);
  assign is_halt   = (rom_data[17:14] == 4'b1111);

  assign rom_addr    = pc_q;
  assign instr_valid = not_empty;
  assign instr       = not_empty ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = not_empty ? addr_q[rd_ptr_q] : '0;
  assign halted      = (state_q == HALT) && !not_empty;

  // Buffer storage; stale contents are masked by the occupancy count.
  always_ff @(posedge clock) begin
    if (enq) begin
      word_q[wr_ptr_q] <= rom_data;
      addr_q[wr_ptr_q] <= pc_q;
    end
  end

  // Fetch state machine, program counter and buffer bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc_q <= redirect_addr;
          end else if (enq) begin
            // The halt marker freezes the PC on its own address.
            if (is_halt) state_q <= HALT;
            else         pc_q    <= pc_q + 10'd1;
          end
        end
        HALT: begin
          if (redirect) begin
            pc_q    <= redirect_addr;
            state_q <= FETCH;
          end else if (start) begin
            pc_q    <= '0;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed bench for instr_fetch with a ROM model and an
//               expected-instruction queue checked on every pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int TB_DEPTH = 2;

  typedef struct packed {
    logic [17:0] w;
    logic [9:0]  pc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [9:0]  rom_addr;
  logic [17:0] rom_data;
  logic        redirect;
  logic [9:0]  redirect_addr;
  logic [17:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  logic [17:0] rom [1024];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  instr_fetch #(.DEPTH(TB_DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .halted        (halted)
  );

  assign rom_data = rom[rom_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [9:0] a);
    exp_t e;
    e.w  = rom[a];
    e.pc = a;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk(tag, sb.size(), 0);
  endtask

  // Every real pop is checked against the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && !redirect && !start && instr_valid && instr_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_mis++;
        $error("FAIL unexpected_pop observed pc=0x%0h word=0x%0h expected no output", instr_pc, instr);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_word", instr, e.w);
        chk("pop_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      rom[a] = {4'h2, a[3:0], a};
    end
    rom[0]     = 18'h00001;
    rom[1]     = 18'h04002;
    rom[2]     = 18'h08003;
    rom[3]     = 18'h3C000;
    rom[10'h203] = 18'h3C123;

    reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;

    // Redirect is ignored while idle.
    redirect = 1'b1; redirect_addr = 10'h055;
    tick();
    redirect = 1'b0;
    chk("idle_redir_addr", rom_addr, 0);
    chk("idle_redir_valid", instr_valid, 0);
    tick();
    chk("idle_nofetch", instr_valid, 0);

    // Straight run to the halt marker with the consumer always ready.
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(10'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_k_valid", instr_valid, 0);
    tick();
    chk("lat_valid", instr_valid, 1);
    chk("run_w0", instr, 18'h00001); chk("run_pc0", instr_pc, 0);
    tick();
    chk("run_w1", instr, 18'h04002); chk("run_pc1", instr_pc, 1);
    tick();
    chk("run_w2", instr, 18'h08003); chk("run_pc2", instr_pc, 2);
    tick();
    chk("run_w3", instr, 18'h3C000); chk("run_pc3", instr_pc, 3);
    chk("run_not_halted", halted, 0);
    chk("halt_pc_hold", rom_addr, 3);
    tick();
    chk("run_halted", halted, 1);
    chk("run_empty", instr_valid, 0);
    chk("run_sb_empty", sb.size(), 0);

    // Restart from HALT with back-pressure; buffer saturates then drains.
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(10'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", halted, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", instr, 18'h00001);
      chk("stall_valid", instr_valid, 1);
    end
    chk("stall_addr", rom_addr, TB_DEPTH);
    instr_ready = 1'b1;
    drain("stall_drain");
    chk("stall_halted", halted, 1);

    // Redirect while the buffer holds two words.
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_redir_valid", instr_valid, 1);
    chk("pre_redir_addr", rom_addr, TB_DEPTH);
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_addr = 10'h200;
    for (int i = 0; i < 4; i++) push(10'h200 + 10'(i));
    tick();
    redirect = 1'b0;
    chk("redir_flush", instr_valid, 0);
    chk("redir_addr", rom_addr, 10'h200);
    tick();
    chk("redir_valid", instr_valid, 1);
    chk("redir_w", instr, rom[10'h200]);
    chk("redir_pc", instr_pc, 10'h200);
    drain("redir_drain");
    chk("redir_halted", halted, 1);

    // PC wrap from 1023 to 0.
    redirect = 1'b1; redirect_addr = 10'd1022;
    push(10'd1022); push(10'd1023);
    for (int i = 0; i < 4; i++) push(10'(i));
    tick();
    redirect = 1'b0;
    drain("wrap_drain");
    chk("wrap_halted", halted, 1);

    // Redirect beats start in the same cycle.
    redirect = 1'b1; start = 1'b1; redirect_addr = 10'h200;
    for (int i = 0; i < 4; i++) push(10'h200 + 10'(i));
    tick();
    redirect = 1'b0; start = 1'b0;
    chk("prio_addr", rom_addr, 10'h200);
    drain("prio_drain");
    chk("prio_halted", halted, 1);

    // Reset mid-operation with two words buffered and PC at 7.
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 10'd5;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("mid_addr", rom_addr, 7);
    chk("mid_valid", instr_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_pc", instr_pc, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_addr", rom_addr, 0);
    tick(); tick();
    chk("mid_rst_idle", instr_valid, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(10'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("post_rst_drain");
    chk("post_rst_halted", halted, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction buffer entries (legal values 2 or 4).
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  begin fetching from address 0.
REQ-005 Port rom_addr  output  10  instruction ROM address; combinational copy of the internal PC.
REQ-006 Port rom_data  input  18  instruction ROM word; combinational read of rom_addr, same cycle.
REQ-007 Port redirect  input  1  taken jump; flush buffer and refetch from redirect_addr.
REQ-008 Port redirect_addr  input  10  jump target.
REQ-009 Port instr  output  18  head-of-buffer instruction.
REQ-010 Port instr_pc  output  10  address the head instruction was fetched from.
REQ-011 Port instr_valid  output  1  head entry valid.
REQ-012 Port instr_ready  input  1  consumer accepts head; pop occurs when instr_valid and instr_ready are both 1.
REQ-013 Port halted  output  1  HALT state reached and buffer empty.

Function
REQ-014 States: IDLE, FETCH, HALT; 10-bit PC; FIFO of DEPTH entries, each {18-bit word, 10-bit pc}; occupancy count 0..DEPTH.
REQ-015 IDLE: no fetch; start=1 -> PC<=0, go FETCH; redirect ignored.
REQ-016 FETCH: enqueue {rom_data, PC} and PC<=PC+1 when count<DEPTH, or count==DEPTH with pop in the same cycle.
REQ-017 PC increments modulo 1024: 1023 -> 0, no flag, no stall.
REQ-018 Enqueued word with opcode rom_data[17:14]==4'b1111 is the halt marker: it is enqueued normally, then state -> HALT, PC not incremented.
REQ-019 HALT: no fetch; buffer continues to drain via pop.
REQ-020 halted = (state==HALT) and count==0; registered/derived from registered state only.
REQ-021 Throughput: one enqueue per cycle, one pop per cycle, both in the same cycle with count unchanged.
REQ-022 Latency: start sampled at edge k -> instr_valid=1, instr=ROM[0], instr_pc=0 after edge k+1.
REQ-023 instr/instr_pc/instr_valid reflect FIFO head only; hold stable while instr_valid=1 and instr_ready=0.
REQ-024 redirect=1 in FETCH or HALT: all entries discarded (count<=0), pop and enqueue in that cycle suppressed, PC<=redirect_addr, state<=FETCH.
REQ-025 After redirect at edge k: first instruction from redirect_addr valid after edge k+1; no pre-redirect word ever presented after edge k.
REQ-026 start=1 in FETCH: ignored; start=1 in HALT: flush, PC<=0, state<=FETCH.
REQ-027 redirect and start in the same cycle outside IDLE: redirect wins.
REQ-028 Full buffer without pop: no enqueue, PC held, rom_addr stable.
REQ-029 Pop on empty buffer (instr_ready=1, instr_valid=0): no effect.

Reset
REQ-030 reset=1 at an edge: state IDLE, PC 0, count 0, instr_valid 0, instr 0, instr_pc 0, halted 0; overrides start, redirect, pop and enqueue.
REQ-031 reset mid-operation discards all buffered instructions; fetching resumes only on a later start.

Verification
REQ-032 ROM[0..3]=0x00001,0x04002,0x08003,0x3C000; start, instr_ready=1 -> instr sequence 0x00001,0x04002,0x08003,0x3C000 on consecutive cycles with instr_pc 0..3, then halted=1 one cycle after last pop.
REQ-033 Same ROM, instr_ready=0 for 5 cycles after start -> count saturates at DEPTH, rom_addr holds at DEPTH, instr=0x00001 stable; release -> no word lost or duplicated.
REQ-034 redirect=1, redirect_addr=0x200 while 2 entries buffered -> instr_valid=0 next cycle, then instr=ROM[0x200], instr_pc=0x200.
REQ-035 redirect_addr=1022, ROM[1022..1023] non-halt, ROM[0]=0x00001 -> instr_pc 1022, 1023, 0 in order.
REQ-036 reset asserted with 2 entries buffered and PC=7 -> outputs all zero next cycle; start ignored-free restart fetches from 0.
REQ-037 In HALT with halted=1, pulse start -> fetch restarts at address 0, halted=0 next cycle.
